// File: rtl/id_pkg.sv
// Shared opcode constants and types for the instruction-decode stage.
package id_pkg;

    localparam logic [5:0] OPC_R    = 6'b101010;
    localparam logic [5:0] OPC_VBNZ = 6'b100010;
    localparam logic [5:0] OPC_VBEZ = 6'b100011;
    localparam logic [5:0] OPC_LD   = 6'b100000;
    localparam logic [5:0] OPC_SD   = 6'b100001;
    localparam logic [5:0] OPC_NOP  = 6'b111100;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_NZ   = 2'b10;
    localparam logic [1:0] BR_EZ   = 2'b11;

    // Fields carried in the ID/EX register
    typedef struct packed {
        logic [4:0]  rs_a;
        logic [4:0]  rs_b;
        logic [4:0]  rd;
        logic [4:0]  ww;
        logic [5:0]  op;
        logic [1:0]  br;
        logic [15:0] imm;
        logic [15:0] mem_addr;
        logic        mem_en;
        logic        store_en;
        logic        load;
        logic        wr_en;
        logic        illegal;
    } dec_t;

    // One in-flight register writer
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

endpackage

// File: rtl/id_decode_comb.sv
// Pure combinational field decoder; also reports which source operands are read.
module id_decode_comb
    import id_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec,
    output logic        use_a,
    output logic        use_b
);

    // Full default first so unused fields stay zero and nothing latches
    always_comb begin
        dec   = '0;
        use_a = 1'b0;
        use_b = 1'b0;
        case (instr[31:26])
            OPC_R: begin
                dec.rs_a  = instr[20:16];
                dec.rs_b  = instr[15:11];
                dec.rd    = instr[25:21];
                dec.ww    = instr[10:6];
                dec.op    = instr[5:0];
                dec.wr_en = 1'b1;
                use_a     = 1'b1;
                use_b     = 1'b1;
            end
            OPC_VBNZ, OPC_VBEZ: begin
                dec.rs_a = instr[25:21];
                dec.br   = (instr[26]) ? BR_EZ : BR_NZ;
                dec.imm  = instr[15:0];
                use_a    = 1'b1;
            end
            OPC_LD: begin
                dec.rd       = instr[25:21];
                dec.mem_addr = instr[15:0];
                dec.mem_en   = 1'b1;
                dec.load     = 1'b1;
                dec.wr_en    = 1'b1;
            end
            OPC_SD: begin
                dec.rs_a     = instr[25:21];
                dec.mem_addr = instr[15:0];
                dec.mem_en   = 1'b1;
                dec.store_en = 1'b1;
                use_a        = 1'b1;
            end
            OPC_NOP: ;
            // Undefined opcodes travel down the pipe as flagged NOPs
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_decode_stage.sv
// Registered decode stage: ID/EX register, RAW scoreboard, flush and stall counter.
module id_decode_stage
    import id_pkg::*;
#(
    parameter int HAZ_DEPTH = 2,
    parameter int FWD_EN    = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    output logic             id_ready,
    input  logic             ex_ready,
    input  logic             flush,
    output logic             ex_valid,
    output logic [4:0]       ex_rs_a,
    output logic [4:0]       ex_rs_b,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_ww,
    output logic [5:0]       ex_op,
    output logic [1:0]       ex_br,
    output logic [15:0]      ex_imm,
    output logic [15:0]      ex_mem_addr,
    output logic             ex_mem_en,
    output logic             ex_store_en,
    output logic             ex_load,
    output logic             ex_wr_en,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    dec_t      dec;
    dec_t      ex_q;
    logic      use_a;
    logic      use_b;
    logic      hazard;
    logic      fire;
    sb_entry_t sb [HAZ_DEPTH];

    id_decode_comb u_dec (
        .instr (if_instr),
        .dec   (dec),
        .use_a (use_a),
        .use_b (use_b)
    );

    // RAW check of the used sources against the in-flight writers.
    // With forwarding only a load sitting in the output register forces a bubble.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (sb[i].valid && (FWD_EN == 0 || (i == 0 && sb[i].is_load))) begin
                if (use_a && dec.rs_a == sb[i].rd) hazard = 1'b1;
                if (use_b && dec.rs_b == sb[i].rd) hazard = 1'b1;
            end
        end
    end

    assign id_ready = ex_ready & ~flush & ~hazard;
    assign fire     = if_valid & id_ready;

    // ID/EX register and scoreboard; flush kills the output slot but older writers keep aging
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q     <= '0;
            ex_valid <= 1'b0;
            for (int i = 0; i < HAZ_DEPTH; i++) sb[i] <= '0;
        end else if (flush) begin
            ex_q     <= '0;
            ex_valid <= 1'b0;
            sb[0]    <= '0;
            if (ex_ready)
                for (int i = 1; i < HAZ_DEPTH; i++) sb[i] <= sb[i-1];
        end else if (ex_ready) begin
            ex_valid <= fire;
            ex_q     <= fire ? dec : '0;
            for (int i = 1; i < HAZ_DEPTH; i++) sb[i] <= sb[i-1];
            if (fire) begin
                sb[0].valid   <= dec.wr_en;
                sb[0].rd      <= dec.rd;
                sb[0].is_load <= dec.load;
            end else begin
                sb[0] <= '0;
            end
        end
    end

    // Saturating count of cycles lost to a hazard bubble
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (if_valid && ex_ready && !flush && hazard && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign ex_rs_a     = ex_q.rs_a;
    assign ex_rs_b     = ex_q.rs_b;
    assign ex_rd       = ex_q.rd;
    assign ex_ww       = ex_q.ww;
    assign ex_op       = ex_q.op;
    assign ex_br       = ex_q.br;
    assign ex_imm      = ex_q.imm;
    assign ex_mem_addr = ex_q.mem_addr;
    assign ex_mem_en   = ex_q.mem_en;
    assign ex_store_en = ex_q.store_en;
    assign ex_load     = ex_q.load;
    assign ex_wr_en    = ex_q.wr_en;
    assign ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench: two stages (no forwarding with a 2-bit counter, load-use forwarding) fed the same stream.
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        reset, if_valid0, if_valid1, ex_ready, flush;
    logic [31:0] if_instr;

    logic        id_ready_0, ex_valid_0, ex_mem_en_0, ex_store_en_0, ex_load_0, ex_wr_en_0, ex_illegal_0;
    logic [4:0]  ex_rs_a_0, ex_rs_b_0, ex_rd_0, ex_ww_0;
    logic [5:0]  ex_op_0;
    logic [1:0]  ex_br_0;
    logic [15:0] ex_imm_0, ex_mem_addr_0;
    logic [1:0]  stall_cnt_0;

    logic        id_ready_1, ex_valid_1, ex_mem_en_1, ex_store_en_1, ex_load_1, ex_wr_en_1, ex_illegal_1;
    logic [4:0]  ex_rs_a_1, ex_rs_b_1, ex_rd_1, ex_ww_1;
    logic [5:0]  ex_op_1;
    logic [1:0]  ex_br_1;
    logic [15:0] ex_imm_1, ex_mem_addr_1;
    logic [15:0] stall_cnt_1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_decode_stage #(.HAZ_DEPTH(2), .FWD_EN(0), .CNT_W(2)) u0 (
        .clk(clk), .reset(reset), .if_valid(if_valid0), .if_instr(if_instr), .id_ready(id_ready_0),
        .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid_0), .ex_rs_a(ex_rs_a_0),
        .ex_rs_b(ex_rs_b_0), .ex_rd(ex_rd_0), .ex_ww(ex_ww_0), .ex_op(ex_op_0), .ex_br(ex_br_0),
        .ex_imm(ex_imm_0), .ex_mem_addr(ex_mem_addr_0), .ex_mem_en(ex_mem_en_0),
        .ex_store_en(ex_store_en_0), .ex_load(ex_load_0), .ex_wr_en(ex_wr_en_0),
        .ex_illegal(ex_illegal_0), .stall_cnt(stall_cnt_0)
    );

    id_decode_stage #(.HAZ_DEPTH(2), .FWD_EN(1), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .if_valid(if_valid1), .if_instr(if_instr), .id_ready(id_ready_1),
        .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid_1), .ex_rs_a(ex_rs_a_1),
        .ex_rs_b(ex_rs_b_1), .ex_rd(ex_rd_1), .ex_ww(ex_ww_1), .ex_op(ex_op_1), .ex_br(ex_br_1),
        .ex_imm(ex_imm_1), .ex_mem_addr(ex_mem_addr_1), .ex_mem_en(ex_mem_en_1),
        .ex_store_en(ex_store_en_1), .ex_load(ex_load_1), .ex_wr_en(ex_wr_en_1),
        .ex_illegal(ex_illegal_1), .stall_cnt(stall_cnt_1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; if_valid0 = 1'b0; if_valid1 = 1'b0; if_instr = '0; ex_ready = 1'b1; flush = 1'b0;
        tick; tick;
        chk("rst_valid0", ex_valid_0, 0);
        chk("rst_valid1", ex_valid_1, 0);
        chk("rst_stall0", stall_cnt_0, 0);
        chk("rst_stall1", stall_cnt_1, 0);
        reset = 1'b0;

        // R-type r3 = r1 op r2
        if_valid0 = 1'b1; if_valid1 = 1'b1; if_instr = 32'hA8611000; #1;
        chk("r_ready", id_ready_0, 1);
        tick;
        chk("r_valid", ex_valid_0, 1);
        chk("r_rd", ex_rd_0, 3);
        chk("r_rs_a", ex_rs_a_0, 1);
        chk("r_rs_b", ex_rs_b_0, 2);
        chk("r_wr_en", ex_wr_en_0, 1);
        chk("r_br", ex_br_0, 0);
        chk("r_ww", ex_ww_0, 0);
        chk("r_op", ex_op_0, 0);
        chk("r_valid1", ex_valid_1, 1);

        // LD r5, 0x0040
        if_instr = 32'h80A00040; tick;
        chk("ld_load", ex_load_0, 1);
        chk("ld_addr", ex_mem_addr_0, 16'h0040);
        chk("ld_mem_en", ex_mem_en_0, 1);
        chk("ld_rd", ex_rd_0, 5);
        chk("ld_load1", ex_load_1, 1);

        // R-type reads r5: load-use hazard in both
        if_instr = 32'hA8C50000; #1;
        chk("lu_ready0", id_ready_0, 0);
        chk("lu_ready1", id_ready_1, 0);
        tick;
        chk("lu_bub0", ex_valid_0, 0);
        chk("lu_bub1", ex_valid_1, 0);
        chk("lu_stall0", stall_cnt_0, 1);
        chk("lu_stall1", stall_cnt_1, 1);

        // Forwarding stage issues; no-forwarding stage still sees LD in slot 1
        chk("fw_ready1", id_ready_1, 1);
        chk("fw_ready0", id_ready_0, 0);
        tick;
        chk("fw_valid1", ex_valid_1, 1);
        chk("fw_rd1", ex_rd_1, 6);
        chk("fw_rs_a1", ex_rs_a_1, 5);
        chk("fw_stall1", stall_cnt_1, 1);
        chk("nf_bub0", ex_valid_0, 0);
        chk("nf_stall0", stall_cnt_0, 2);

        // Only the no-forwarding stage still presents it
        if_valid1 = 1'b0; #1;
        chk("nf_ready0", id_ready_0, 1);
        tick;
        chk("nf_valid0", ex_valid_0, 1);
        chk("nf_rd0", ex_rd_0, 6);
        chk("nf_stall0b", stall_cnt_0, 2);
        chk("idle_valid1", ex_valid_1, 0);
        chk("idle_stall1", stall_cnt_1, 1);

        // Illegal opcode
        if_valid1 = 1'b1; if_instr = 32'h00000000; tick;
        chk("il_valid", ex_valid_0, 1);
        chk("il_flag", ex_illegal_0, 1);
        chk("il_wr_en", ex_wr_en_0, 0);
        chk("il_mem_en", ex_mem_en_0, 0);
        chk("il_store", ex_store_en_0, 0);
        chk("il_load", ex_load_0, 0);
        chk("il_br", ex_br_0, 0);
        chk("il_flag1", ex_illegal_1, 1);

        // Reader of r0 right after the illegal op: no hazard from it
        if_instr = 32'hA8000000; #1;
        chk("nohz_ready0", id_ready_0, 1);
        chk("nohz_ready1", id_ready_1, 1);
        tick;
        chk("nohz_valid", ex_valid_0, 1);
        chk("nohz_illegal", ex_illegal_0, 0);

        // VBNZ r4, 0x0010
        if_instr = 32'h88800010; tick;
        chk("br_code", ex_br_0, 2'b10);
        chk("br_imm", ex_imm_0, 16'h0010);
        chk("br_rs_a", ex_rs_a_0, 4);
        chk("br_wr_en", ex_wr_en_0, 0);
        chk("br_code1", ex_br_1, 2'b10);

        // Flush while u0 also has a hazard on r0
        flush = 1'b1; if_instr = 32'hA8000000; #1;
        chk("fl_ready0", id_ready_0, 0);
        chk("fl_ready1", id_ready_1, 0);
        tick;
        chk("fl_valid0", ex_valid_0, 0);
        chk("fl_valid1", ex_valid_1, 0);
        chk("fl_stall0", stall_cnt_0, 2);
        chk("fl_stall1", stall_cnt_1, 1);

        // Load the output register, then hold it for 3 cycles
        flush = 1'b0; if_instr = 32'hA8611000; tick;
        chk("pre_hold_rd", ex_rd_0, 3);
        ex_ready = 1'b0; if_instr = 32'hA8C50000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_ready", id_ready_0, 0);
            tick;
            chk("hold_valid", ex_valid_0, 1);
            chk("hold_rd", ex_rd_0, 3);
            chk("hold_rs_a", ex_rs_a_0, 1);
            chk("hold_rs_b", ex_rs_b_0, 2);
            chk("hold_stall", stall_cnt_0, 2);
        end

        // Saturation of the 2-bit counter
        ex_ready = 1'b1; if_instr = 32'h80A00040; tick;
        chk("sat_ld", ex_load_0, 1);
        if_instr = 32'hA8C50000; tick;
        chk("sat_stall3", stall_cnt_0, 3);
        chk("sat_stall1", stall_cnt_1, 2);
        chk("sat_bub", ex_valid_0, 0);
        if_valid1 = 1'b0; tick;
        chk("sat_hold", stall_cnt_0, 3);
        chk("sat_bub2", ex_valid_0, 0);
        chk("sat_stall1b", stall_cnt_1, 2);

        // Reset in the middle of a load-use stall
        if_valid1 = 1'b1; if_instr = 32'h80A00040; tick;
        chk("rs_ld", ex_load_0, 1);
        if_instr = 32'hA8C50000; #1;
        chk("rs_ready0", id_ready_0, 0);
        chk("rs_ready1", id_ready_1, 0);
        reset = 1'b1; tick;
        chk("rs_valid0", ex_valid_0, 0);
        chk("rs_valid1", ex_valid_1, 0);
        chk("rs_stall0", stall_cnt_0, 0);
        chk("rs_stall1", stall_cnt_1, 0);
        chk("rs_load", ex_load_0, 0);
        reset = 1'b0; #1;
        chk("rs_ready0b", id_ready_0, 1);
        chk("rs_ready1b", id_ready_1, 1);
        tick;
        chk("rs_reissue0", ex_valid_0, 1);
        chk("rs_reissue_rd", ex_rd_0, 6);
        chk("rs_reissue1", ex_valid_1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
